addsub_arbiter: RTL and testbench
=================================

ADDSUB_ARBITER -- requirements
Module: addsub_arbiter

Interface
REQ-001 Parameter: WIDTH, 16, operand/result width of the shared add/sub unit.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 req0_valid / req1_valid  in  1  requester N presents an operation.
REQ-005 req0_a, req0_b / req1_a, req1_b  in  WIDTH  operands of requester N.
REQ-006 req0_sub / req1_sub  in  1  0 = add, 1 = subtract (a - b).
REQ-007 req0_ready / req1_ready  out  1  combinational; operation of requester N accepted this cycle.
REQ-008 alu_a, alu_b  out  WIDTH  operands driven to the external add/sub unit.
REQ-009 alu_sub  out  1  operation select driven to the external unit.
REQ-010 alu_s  in  WIDTH  external unit sum/difference.
REQ-011 alu_cout  in  1  external unit carry (add) or inverted borrow (sub).
REQ-012 rsp0_valid / rsp1_valid  out  1  result for requester N available.
REQ-013 rsp0_ready / rsp1_ready  in  1  requester N consumes the result.
REQ-014 rsp_s  out  WIDTH  registered result, shared by both response ports.
REQ-015 rsp_cout  out  1  registered carry / inverted borrow.
REQ-016 busy  out  1  high in any state other than IDLE.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, EXEC, RESP.
REQ-018 IDLE: if any reqN_valid is high, the block SHALL grant one requester, assert only its reqN_ready that cycle, register its a/b/sub and the grant id, and enter EXEC.
REQ-019 Arbitration SHALL be round-robin: priority pointer selects the favoured port; a lone valid requester is always granted.
REQ-020 After reset the pointer SHALL favour port 0; on each RESP exit it SHALL move to the port not just served.
REQ-021 reqN_ready SHALL be low in EXEC and RESP, and in IDLE for the non-granted port.
REQ-022 alu_a/alu_b/alu_sub SHALL be driven directly from the operand registers at all times (no combinational path from req inputs).
REQ-023 EXEC: the block SHALL capture alu_s into rsp_s and alu_cout into rsp_cout at the clock edge ending EXEC, then enter RESP.
REQ-024 EXEC SHALL last exactly one cycle; accept on edge N yields rspN_valid high in the cycle after edge N+1 (2-cycle latency).
REQ-025 RESP: only the granted port's rspN_valid SHALL be high; rsp_s/rsp_cout SHALL stay stable while rspN_valid is high.
REQ-026 RESP SHALL hold until the granted rspN_ready is high at a clock edge, then enter IDLE; the other port's rsp_ready SHALL be ignored.
REQ-027 A request arriving during EXEC/RESP SHALL wait; the requester keeps valid/operands stable until ready.
REQ-028 No new request SHALL be accepted in the RESP-exit cycle; minimum spacing between accepts is 3 cycles.
REQ-029 The block SHALL NOT modify arithmetic results; width and carry semantics are those of the external unit.

Reset
REQ-030 While rst is high: state = IDLE, pointer = port 0, operand registers = 0, alu_sub = 0, rsp_s = 0, rsp_cout = 0, all reqN_ready/rspN_valid = 0, busy = 0.
REQ-031 rst asserted mid-operation (EXEC or RESP) SHALL abort the transaction immediately; no response for it is ever issued.
REQ-032 The first grant after rst deasserts SHALL be possible on the first rising edge with rst low.

Verification
REQ-033 Port 0 add 0x0003 + 0x0004, rsp0_ready high -> rsp0_valid two cycles after accept, rsp_s = 0x0007, rsp_cout = 0.
REQ-034 Port 1 add 0xFFFF + 0x0001 -> rsp_s = 0x0000, rsp_cout = 1; sub 0x0007 - 0x0005 -> 0x0002, cout 1; sub 0x0005 - 0x0007 -> 0xFFFE, cout 0.
REQ-035 Both valid from reset, port0 = 0x0010+0x0001, port1 = 0x0020-0x0001 -> port 0 served first (0x0011), then port 1 (0x001F); repeat both -> order alternates.
REQ-036 rsp0_ready held low 3 cycles in RESP -> rsp0_valid, rsp_s, busy stay constant; req1_valid meanwhile sees req1_ready = 0.
REQ-037 rst pulsed during EXEC of port 0 op -> all outputs return to reset values, no rsp0_valid; next port 0 request completes normally.
REQ-038 Only port 1 valid continuously for 4 ops with pointer favouring port 0 -> all 4 granted to port 1, one accept every 3 cycles.

Source files
------------

// File: rtl/addsub_arbiter.sv
// Round-robin front end that shares one external add/sub unit between two requesters.
// Accept to response is 2 cycles. Results are held until the granted port takes them, and accepts are at least 3 cycles apart.
module addsub_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_sub,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_sub,
  output logic             req1_ready,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_sub,
  input  logic [WIDTH-1:0] alu_s,
  input  logic             alu_cout,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_s,
  output logic             rsp_cout,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state;
  logic             ptr;
  logic             gnt;
  logic             sel;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_sub;

  // The pointer only matters on contention; a lone requester always wins.
  assign sel = (req0_valid && req1_valid) ? ptr : req1_valid;

  assign req0_ready = !rst && (state == IDLE) && req0_valid && !sel;
  assign req1_ready = !rst && (state == IDLE) && req1_valid && sel;

  assign alu_a   = op_a;
  assign alu_b   = op_b;
  assign alu_sub = op_sub;

  assign rsp0_valid = (state == RESP) && !gnt;
  assign rsp1_valid = (state == RESP) && gnt;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= 1'b0;
      gnt      <= 1'b0;
      op_a     <= '0;
      op_b     <= '0;
      op_sub   <= 1'b0;
      rsp_s    <= '0;
      rsp_cout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req0_valid || req1_valid) begin
            gnt    <= sel;
            op_a   <= sel ? req1_a : req0_a;
            op_b   <= sel ? req1_b : req0_b;
            op_sub <= sel ? req1_sub : req0_sub;
            state  <= EXEC;
          end
        end
        EXEC: begin
          rsp_s    <= alu_s;
          rsp_cout <= alu_cout;
          state    <= RESP;
        end
        RESP: begin
          // Only the granted port's ready can release the result.
          if (gnt ? rsp1_ready : rsp0_ready) begin
            ptr   <= ~gnt;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed bench for addsub_arbiter with a behavioural model of the external add/sub unit.
module tb_addsub_arbiter;
  localparam int W = 16;

  typedef struct {
    int         port;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic       sub;
    logic [W-1:0] s;
    logic       c;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req0_sub, req0_ready;
  logic         req1_valid, req1_sub, req1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [W-1:0] alu_a, alu_b, alu_s, rsp_s, perturb;
  logic         alu_sub, alu_cout;
  logic         rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready, rsp_cout, busy;
  logic [W:0]   alu_sum;
  int           checks = 0;
  int           passed = 0;
  int           cyc = 0;

  addsub_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub), .req1_ready(req1_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sub(alu_sub), .alu_s(alu_s), .alu_cout(alu_cout),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_s(rsp_s), .rsp_cout(rsp_cout), .busy(busy)
  );

  // External unit: cout is carry for add, inverted borrow for subtract.
  assign alu_sum  = alu_sub ? ({1'b0, alu_a} + {1'b0, ~alu_b} + 17'd1) : ({1'b0, alu_a} + {1'b0, alu_b});
  assign alu_s    = alu_sum[W-1:0] ^ perturb;
  assign alu_cout = alu_sum[W];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic set_req(input int p, input logic v, input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    if (p == 0) begin
      req0_valid = v; req0_a = a; req0_b = b; req0_sub = s;
    end else begin
      req1_valid = v; req1_a = a; req1_b = b; req1_sub = s;
    end
  endtask

  // Waits (bounded) for a grant; returns the granted port and the cycle of the accept edge, leaves time in EXEC.
  task automatic accept_any(input bit drop, output int port, output int at);
    bit ok;
    ok = 1'b0; port = -1; at = -1;
    for (int i = 0; i < 20 && !ok; i++) begin
      #1;
      if (req0_ready || req1_ready) begin
        ok = 1'b1; port = req1_ready ? 1 : 0; at = cyc;
      end else begin
        step();
      end
    end
    if (!ok) begin
      checks++;
      $display("FAIL accept_timeout: got no ready in 20 cycles, required a grant");
    end
    step();
    if (drop && ok) set_req(port, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic finish_rsp(input int p, input logic [W-1:0] s, input logic c, input string tag);
    check({tag, " exec_busy"}, busy, 1);
    check({tag, " exec_novalid"}, rsp0_valid | rsp1_valid, 0);
    step();
    check({tag, " rsp_valid"}, (p == 0) ? rsp0_valid : rsp1_valid, 1);
    check({tag, " other_valid"}, (p == 0) ? rsp1_valid : rsp0_valid, 0);
    check({tag, " rsp_s"}, rsp_s, s);
    check({tag, " rsp_cout"}, rsp_cout, c);
    step();
    check({tag, " idle_busy"}, busy, 0);
  endtask

  task automatic do_op(input int p, input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                       input logic [W-1:0] s, input logic c, input string tag);
    int port, at;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    set_req(p, 1'b1, a, b, sub);
    accept_any(1'b1, port, at);
    check({tag, " grant"}, port, p);
    finish_rsp(p, s, c, tag);
  endtask

  initial begin
    vec_t tbl [7];
    int   port, at, prev;
    logic [W-1:0] ea, eb, es;

    tbl[0] = '{port: 1, a: 16'hFFFF, b: 16'h0001, sub: 1'b0, s: 16'h0000, c: 1'b1};
    tbl[1] = '{port: 1, a: 16'h0007, b: 16'h0005, sub: 1'b1, s: 16'h0002, c: 1'b1};
    tbl[2] = '{port: 1, a: 16'h0005, b: 16'h0007, sub: 1'b1, s: 16'hFFFE, c: 1'b0};
    tbl[3] = '{port: 0, a: 16'h1234, b: 16'h1111, sub: 1'b0, s: 16'h2345, c: 1'b0};
    tbl[4] = '{port: 0, a: 16'h8000, b: 16'h8000, sub: 1'b0, s: 16'h0000, c: 1'b1};
    tbl[5] = '{port: 0, a: 16'h0000, b: 16'h0000, sub: 1'b1, s: 16'h0000, c: 1'b1};
    tbl[6] = '{port: 1, a: 16'h7FFF, b: 16'h0001, sub: 1'b0, s: 16'h8000, c: 1'b0};

    rst = 1'b1; perturb = '0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    set_req(1, 1'b0, '0, '0, 1'b0);
    set_req(0, 1'b1, 16'h0003, 16'h0004, 1'b0);
    step(); step();
    check("rst req0_ready", req0_ready, 0);
    check("rst busy", busy, 0);
    check("rst rsp0_valid", rsp0_valid, 0);
    check("rst rsp_s", rsp_s, 0);
    check("rst rsp_cout", rsp_cout, 0);
    check("rst alu_a", alu_a, 0);
    check("rst alu_sub", alu_sub, 0);

    // First edge after reset release already grants.
    rst = 1'b0;
    #1;
    check("first_grant req0_ready", req0_ready, 1);
    step();
    set_req(0, 1'b0, '0, '0, 1'b0);
    check("exec alu_a", alu_a, 16'h0003);
    finish_rsp(0, 16'h0007, 1'b0, "add3p4");

    for (int i = 0; i < 7; i++)
      do_op(tbl[i].port, tbl[i].a, tbl[i].b, tbl[i].sub, tbl[i].s, tbl[i].c, $sformatf("vec%0d", i));

    // Response backpressure: result must hold while the ALU output wanders and port 1 waits.
    rsp0_ready = 1'b0;
    set_req(0, 1'b1, 16'h0100, 16'h0023, 1'b0);
    accept_any(1'b1, port, at);
    check("bp grant", port, 0);
    set_req(1, 1'b1, 16'h0050, 16'h0005, 1'b1);
    step();
    perturb = 16'hA5A5;
    for (int k = 0; k < 3; k++) begin
      check("bp rsp0_valid", rsp0_valid, 1);
      check("bp rsp1_valid", rsp1_valid, 0);
      check("bp rsp_s", rsp_s, 16'h0123);
      check("bp busy", busy, 1);
      check("bp req1_ready", req1_ready, 0);
      step();
    end
    rsp0_ready = 1'b1; perturb = '0;
    step();
    accept_any(1'b1, port, at);
    check("bp waiting grant", port, 1);
    finish_rsp(1, 16'h004B, 1'b1, "bp_sub");

    // Reset during EXEC aborts the transaction.
    set_req(0, 1'b1, 16'h0003, 16'h0004, 1'b0);
    accept_any(1'b1, port, at);
    set_req(0, 1'b1, 16'h0003, 16'h0004, 1'b0);
    rst = 1'b1;
    #1;
    check("abort busy", busy, 0);
    check("abort rsp0_valid", rsp0_valid, 0);
    check("abort rsp_s", rsp_s, 0);
    check("abort alu_a", alu_a, 0);
    check("abort req0_ready", req0_ready, 0);
    set_req(0, 1'b0, '0, '0, 1'b0);
    step();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("abort no rsp0_valid", rsp0_valid, 0);
    end
    do_op(0, 16'h0009, 16'h0001, 1'b1, 16'h0008, 1'b1, "after_abort");

    // Contention from reset: port 0 first, then port 1, and again.
    rst = 1'b1; step(); rst = 1'b0;
    for (int r = 0; r < 2; r++) begin
      set_req(0, 1'b1, 16'h0010, 16'h0001, 1'b0);
      set_req(1, 1'b1, 16'h0020, 16'h0001, 1'b1);
      accept_any(1'b1, port, at);
      check("rr first", port, 0);
      finish_rsp(0, 16'h0011, 1'b0, "rr p0");
      accept_any(1'b1, port, at);
      check("rr second", port, 1);
      finish_rsp(1, 16'h001F, 1'b1, "rr p1");
    end

    // Port 1 alone, continuously valid, while the pointer favours port 0.
    rst = 1'b1; step(); rst = 1'b0;
    set_req(0, 1'b0, '0, '0, 1'b0);
    prev = -1;
    for (int i = 0; i < 4; i++) begin
      ea = 16'h0109 + 16'(i * 16'h0100);
      eb = 16'(i + 1);
      es = i[0] ? (ea - eb) : (ea + eb);
      set_req(1, 1'b1, ea, eb, i[0]);
      accept_any(1'b0, port, at);
      check("solo grant", port, 1);
      if (prev >= 0) check("solo spacing", at - prev, 3);
      prev = at;
      finish_rsp(1, es, i[0], "solo");
    end
    set_req(1, 1'b0, '0, '0, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
